// File: rtl/fetch_queue_unit.sv
// Fetch stage: PC generation, redirect resolution, pipelined imem port and a prefetch FIFO to decode.
// Optional build macro FETCH_BYPASS_EN lets a response reach decode directly when the FIFO is empty.
module fetch_queue_unit #(
    parameter int               XLEN     = 32,
    parameter int               IMEM_AW  = 12,
    parameter int               FQ_DEPTH = 4,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               b_en,
    input  logic               UJ_en,
    input  logic               jalr,
    input  logic [XLEN-1:0]    redir_pc,
    input  logic [XLEN-1:0]    al,
    input  logic [XLEN-1:0]    UJimm,
    input  logic [XLEN-1:0]    SBimm,
    input  logic               stall,
    output logic               imem_req,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic               imem_ready,
    input  logic [31:0]        imem_rdata,
    output logic               inst_valid,
    output logic [31:0]        inst,
    output logic [XLEN-1:0]    pc
);

    localparam int            PW      = $clog2(FQ_DEPTH);
    localparam int            CW      = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FQ_DEPTH);
    localparam logic [31:0]   NOP     = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     inst;
    } fq_entry_t;

    logic [XLEN-1:0] r_fpc;
    logic [XLEN-1:0] r_issued_pc;
    logic            r_inflight;
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    fq_entry_t       r_fifo [FQ_DEPTH];

    logic            w_redirect;
    logic [XLEN-1:0] w_target_raw;
    logic [XLEN-1:0] w_target;
    logic [CW-1:0]   w_occupancy;
    logic            w_accept;
    logic            w_resp;
    logic            w_head_valid;
    logic            w_push;
    logic            w_pop;
    fq_entry_t       w_head;

    // Redirect target selection: jalr wins over jal, jal over a taken branch.
    always_comb begin
        // NOTE: default assignment first so every path drives the signal and no latch is inferred.
        w_target_raw = redir_pc + SBimm;
        if (jalr) begin
            w_target_raw = al & ~XLEN'(1);
        end else if (UJ_en) begin
            w_target_raw = redir_pc + UJimm;
        end
    end

    assign w_target   = {w_target_raw[XLEN-1:2], 2'b00};
    assign w_redirect = b_en | UJ_en | jalr;

    // A request is only issued when its response is guaranteed a FIFO slot.
    assign w_occupancy = r_count + CW'(r_inflight);
    assign imem_req    = !w_redirect && (w_occupancy < DEPTH_C);
    assign imem_addr   = r_fpc[IMEM_AW+1:2];
    assign w_accept    = imem_req && imem_ready;

    // A response arriving in a redirect cycle is wrong-path and is dropped.
    assign w_resp       = r_inflight && !w_redirect;
    assign w_head_valid = (r_count != '0);
    assign w_head       = r_fifo[r_rd_ptr];
    assign w_pop        = w_head_valid && !stall;

`ifdef FETCH_BYPASS_EN
    logic w_bypass;

    assign w_bypass   = w_resp && !w_head_valid;
    assign w_push     = w_resp && !(w_bypass && !stall);
    assign inst_valid = w_head_valid || w_bypass;
    assign inst       = w_head_valid ? w_head.inst : (w_bypass ? imem_rdata  : NOP);
    assign pc         = w_head_valid ? w_head.pc   : (w_bypass ? r_issued_pc : RESET_PC);
`else
    assign w_push     = w_resp;
    assign inst_valid = w_head_valid;
    assign inst       = w_head_valid ? w_head.inst : NOP;
    assign pc         = w_head_valid ? w_head.pc   : RESET_PC;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
            r_fpc       <= RESET_PC;
            r_issued_pc <= RESET_PC;
            r_inflight  <= 1'b0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
        end else if (w_redirect) begin
            r_fpc      <= w_target;
            r_inflight <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else begin
            if (w_accept) begin
                r_fpc       <= r_fpc + XLEN'(4);
                r_issued_pc <= r_fpc;
            end
            r_inflight <= w_accept;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: storage is not reset; r_count alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (w_push && !w_redirect) begin
            r_fifo[r_wr_ptr] <= '{pc: r_issued_pc, inst: imem_rdata};
        end
    end

    // A response must always find a free slot because issue reserves one.
    a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
        !(w_push && !w_pop && r_count == DEPTH_C));

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed self-checking bench for fetch_queue_unit with a 1-cycle-latency imem model.
module tb_fetch_queue_unit;

    localparam int XLEN     = 32;
    localparam int IMEM_AW  = 12;
    localparam int FQ_DEPTH = 4;
`ifdef FETCH_BYPASS_EN
    localparam int REDIR_LAT = 2;
`else
    localparam int REDIR_LAT = 3;
`endif

    logic               clk = 1'b0;
    logic               reset;
    logic               b_en, UJ_en, jalr;
    logic [XLEN-1:0]    redir_pc, al, UJimm, SBimm;
    logic               stall;
    logic               imem_req;
    logic [IMEM_AW-1:0] imem_addr;
    logic               imem_ready;
    logic [31:0]        imem_rdata;
    logic               inst_valid;
    logic [31:0]        inst;
    logic [XLEN-1:0]    pc;

    int n_cmp = 0;
    int n_err = 0;
    int n_issued = 0;
    int cyc = 0;
    logic [31:0] q_pc[$];
    logic [31:0] q_inst[$];
    int          q_cyc[$];

    always #5 clk = ~clk;

    fetch_queue_unit #(
        .XLEN(XLEN), .IMEM_AW(IMEM_AW), .FQ_DEPTH(FQ_DEPTH), .RESET_PC(32'h0000_0000)
    ) dut (
        .clk(clk), .reset(reset), .b_en(b_en), .UJ_en(UJ_en), .jalr(jalr),
        .redir_pc(redir_pc), .al(al), .UJimm(UJimm), .SBimm(SBimm), .stall(stall),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rdata(imem_rdata), .inst_valid(inst_valid), .inst(inst), .pc(pc)
    );

    // Memory content: each word holds a tag plus its own word address.
    always @(posedge clk) begin
        imem_rdata <= (imem_req && imem_ready) ? (32'hA000_0000 | {20'h0, imem_addr})
                                               : 32'hDEAD_BEEF;
    end

    function automatic logic [31:0] exp_inst(input logic [31:0] p);
        return 32'hA000_0000 | {20'h0, p[13:2]};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Samples away from the edge, records what decode consumes, then advances one cycle.
    task automatic tick();
        #1;
        if (imem_req && imem_ready) n_issued++;
        if (reset && inst_valid && !stall && !(b_en || UJ_en || jalr)) begin
            q_pc.push_back(pc);
            q_inst.push_back(inst);
            q_cyc.push_back(cyc);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic clear_redirect();
        b_en = 1'b0; UJ_en = 1'b0; jalr = 1'b0;
        redir_pc = '0; al = '0; UJimm = '0; SBimm = '0;
    endtask

    task automatic clear_log();
        q_pc.delete();
        q_inst.delete();
        q_cyc.delete();
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        clear_redirect();
        stall = 1'b0;
        imem_ready = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        n_issued = 0;
        clear_log();
    endtask

    task automatic check_stream(input string tag, input logic [31:0] base, input int n,
                                input bit consecutive);
        logic [31:0] exp_pc;
        check({tag, " enough"}, (q_pc.size() >= n) ? 32'd1 : 32'd0, 32'd1);
        if (q_pc.size() < n) return;
        for (int i = 0; i < n; i++) begin
            exp_pc = base + 32'(4 * i);
            check($sformatf("%s pc[%0d]", tag, i), q_pc[i], exp_pc);
            check($sformatf("%s inst[%0d]", tag, i), q_inst[i], exp_inst(exp_pc));
            if (consecutive && i > 0)
                check($sformatf("%s gap[%0d]", tag, i), 32'(q_cyc[i] - q_cyc[i-1]), 32'd1);
        end
    endtask

    task automatic wait_redirect_result(input string tag, input logic [31:0] exp_pc);
        check({tag, " empty E0"}, 32'(inst_valid), 32'd0);
        for (int i = 1; i < REDIR_LAT - 1; i++) begin
            tick();
            check($sformatf("%s empty E%0d", tag, i), 32'(inst_valid), 32'd0);
        end
        tick();
        check({tag, " valid"}, 32'(inst_valid), 32'd1);
        check({tag, " pc"}, pc, exp_pc);
        check({tag, " inst"}, inst, exp_inst(exp_pc));
    endtask

    initial begin
        logic rdy_pat [6];
        logic [11:0] addr_pat [6];
        int stale;
        rdy_pat  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        addr_pat = '{12'd0, 12'd1, 12'd1, 12'd2, 12'd2, 12'd3};

        // 1: reset mid-stream with FIFO partly filled
        apply_reset();
        check("t1 reset valid", 32'(inst_valid), 32'd0);
        check("t1 reset inst", inst, 32'h0000_0013);
        check("t1 reset pc", pc, 32'h0);
        stall = 1'b1;
        tick(); tick(); tick();
        check("t1 prefill valid", 32'(inst_valid), 32'd1);
        reset = 1'b0;
        #1;
        check("t1 async valid", 32'(inst_valid), 32'd0);
        check("t1 async inst", inst, 32'h0000_0013);
        check("t1 async pc", pc, 32'h0);
        tick();
        reset = 1'b1;
        stall = 1'b0;
        clear_log();
        for (int i = 0; i < 7; i++) tick();
        check_stream("t1 stream", 32'h0, 4, 1'b1);

        // 2: long stall fills exactly FQ_DEPTH entries
        apply_reset();
        stall = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        check("t2 issued", 32'(n_issued), 32'(FQ_DEPTH));
        check("t2 req off", 32'(imem_req), 32'd0);
        check("t2 head valid", 32'(inst_valid), 32'd1);
        check("t2 head pc", pc, 32'h0);
        clear_log();
        stall = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check_stream("t2 drain", 32'h0, 5, 1'b1);

        // 3: taken branch while a response is in flight
        apply_reset();
        tick();
        b_en = 1'b1; redir_pc = 32'h40; SBimm = 32'hFFFF_FFF0;
        #1;
        check("t3 no req on redirect", 32'(imem_req), 32'd0);
        tick();
        clear_redirect();
        check("t3 fetch addr", 32'(imem_addr), 32'h0C);
        wait_redirect_result("t3", 32'h30);
        tick();
        check("t3 next pc", pc, 32'h34);

        // 4: jalr and jal together, jalr wins and low bits are cleared
        jalr = 1'b1; UJ_en = 1'b1; al = 32'h123; UJimm = 32'h100; redir_pc = 32'h0;
        tick();
        clear_redirect();
        check("t4 fetch addr", 32'(imem_addr), 32'h48);
        wait_redirect_result("t4", 32'h120);

        // fpc and imem_addr wrap at the top of the address space
        clear_log();
        jalr = 1'b1; al = 32'hFFFF_FFFD;
        tick();
        clear_redirect();
        check("wrap addr top", 32'(imem_addr), 32'hFFF);
        tick();
        check("wrap addr zero", 32'(imem_addr), 32'h0);
        for (int i = 0; i < 4; i++) tick();
        check_stream("wrap stream", 32'hFFFF_FFFC, 2, 1'b1);

        // 5: imem_ready toggling holds the address and preserves order
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            imem_ready = rdy_pat[i];
            #1;
            check($sformatf("t5 addr c%0d", i), 32'(imem_addr), 32'(addr_pat[i]));
            tick();
        end
        imem_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check_stream("t5 order", 32'h0, 3, 1'b0);

        // 6: redirect while FIFO full and decode dequeuing
        apply_reset();
        stall = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        clear_log();
        stall = 1'b0;
        b_en = 1'b1; redir_pc = 32'h200; SBimm = 32'h80;
        #1;
        check("t6 full head valid", 32'(inst_valid), 32'd1);
        check("t6 full head pc", pc, 32'h0);
        check("t6 no req", 32'(imem_req), 32'd0);
        tick();
        clear_redirect();
        check("t6 flushed", 32'(inst_valid), 32'd0);
        for (int i = 0; i < 6; i++) tick();
        check_stream("t6 new path", 32'h280, 3, 1'b1);
        stale = 0;
        foreach (q_pc[i]) if (q_pc[i] < 32'h280) stale++;
        check("t6 stale pcs", 32'(stale), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
